// File: rtl/qgate_pkg.sv
// Shared constants and helpers for the single-qubit gate engine.
// Gate encodings, the 1/sqrt(2) scale factor and a saturating clamp.
package qgate_pkg;

  localparam logic [1:0] QG_I = 2'd0;
  localparam logic [1:0] QG_X = 2'd1;
  localparam logic [1:0] QG_Z = 2'd2;
  localparam logic [1:0] QG_H = 2'd3;

  localparam int SAT_W = 66;

  typedef struct packed {
    logic        sat;
    logic [31:0] val;
  } sat_t;

  // round(2^frac / sqrt(2)) == round(sqrt(2^(2*frac+1)) / 2)
  function automatic logic [63:0] inv_sqrt2_q(input int frac);
    logic [63:0] n;
    logic [63:0] r;
    logic [63:0] t;
    n = 64'd1 << (2 * frac + 1);
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      t = r | (64'd1 << i);
      if (t * t <= n) r = t;
    end
    return (r + 64'd1) >> 1;
  endfunction

  function automatic sat_t sat_trunc(
    input logic signed [SAT_W-1:0] v,
    input int                      w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_t r;
    hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
    lo = -hi - SAT_W'(1);
    r.sat = 1'b0;
    r.val = v[31:0];
    if (v > hi) begin
      r.sat = 1'b1;
      r.val = hi[31:0];
    end else if (v < lo) begin
      r.sat = 1'b1;
      r.val = lo[31:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/qgate_scale_sat.sv
// One Hadamard lane: multiply by K, round half up, clamp to WIDTH.
// Input is the WIDTH+1 bit sum or difference from stage 1.
module qgate_scale_sat #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic signed [WIDTH:0]   a,
  output logic        [WIDTH-1:0] y,
  output logic                    sat
);
  import qgate_pkg::*;

  localparam int PW = WIDTH + FRAC + 3;
  localparam logic signed [PW-1:0] K =
    PW'(inv_sqrt2_q(FRAC));
  localparam logic signed [PW-1:0] RND =
    PW'((64'd1 << FRAC) >> 1);

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] rnd;
  sat_t r;

  always_comb begin
    prod = PW'(a) * K;
    rnd  = (prod + RND) >>> FRAC;
    r    = sat_trunc(SAT_W'(rnd), WIDTH);
    y    = WIDTH'(r.val);
    sat  = r.sat;
  end

endmodule

// File: rtl/qgate_pipe.sv
// Two-stage streaming gate engine (I, X, Z, H) on an amplitude pair.
// Valid/ready on both sides; results are rounded and saturated.
module qgate_pipe #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_alpha,
  input  logic [WIDTH-1:0] in_beta,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_alpha,
  output logic [WIDTH-1:0] out_beta,
  output logic             out_sat,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);
  import qgate_pkg::*;

  logic s1_v;
  logic s2_v;
  logic s1_load;
  logic s2_load;
  logic [1:0] s1_mode;
  logic signed [WIDTH:0] s1_a;
  logic signed [WIDTH:0] s1_b;
  logic signed [WIDTH:0] ea;
  logic signed [WIDTH:0] eb;
  logic signed [WIDTH:0] n_a;
  logic signed [WIDTH:0] n_b;
  logic [WIDTH-1:0] h_a;
  logic [WIDTH-1:0] h_b;
  logic [WIDTH-1:0] d_a;
  logic [WIDTH-1:0] d_b;
  logic h_sa;
  logic h_sb;
  logic d_sat;
  sat_t ta;
  sat_t tb;

  assign s2_load   = !s2_v || out_ready;
  assign s1_load   = !s1_v || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_v;

  always_comb begin
    ea  = {in_alpha[WIDTH-1], in_alpha};
    eb  = {in_beta[WIDTH-1], in_beta};
    n_a = ea;
    n_b = eb;
    unique case (1'b1)
      (in_mode == QG_H): begin
        n_a = ea + eb;
        n_b = ea - eb;
      end
      (in_mode == QG_X): begin
        n_a = eb;
        n_b = ea;
      end
      (in_mode == QG_Z): n_b = -eb;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s1_v <= 1'b0;
    else if (s1_load) s1_v <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (s1_load && in_valid) begin
      s1_mode <= in_mode;
      s1_a    <= n_a;
      s1_b    <= n_b;
    end
  end

  qgate_scale_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_sa (
    .a   (s1_a),
    .y   (h_a),
    .sat (h_sa)
  );

  qgate_scale_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_sb (
    .a   (s1_b),
    .y   (h_b),
    .sat (h_sb)
  );

  // only Z of the most negative beta can exceed WIDTH off the H path
  always_comb begin
    ta = sat_trunc(SAT_W'(s1_a), WIDTH);
    tb = sat_trunc(SAT_W'(s1_b), WIDTH);
    if (s1_mode == QG_H) begin
      d_a   = h_a;
      d_b   = h_b;
      d_sat = h_sa || h_sb;
    end else begin
      d_a   = WIDTH'(ta.val);
      d_b   = WIDTH'(tb.val);
      d_sat = ta.sat || tb.sat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v      <= 1'b0;
      out_alpha <= '0;
      out_beta  <= '0;
      out_sat   <= 1'b0;
    end else if (s2_load) begin
      s2_v <= s1_v;
      if (s1_v) begin
        out_alpha <= d_a;
        out_beta  <= d_b;
        out_sat   <= d_sat;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_sticky <= 1'b0;
    else if (out_valid && out_ready && out_sat) ovf_sticky <= 1'b1;
    else if (ovf_clr) ovf_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_qgate_pipe.sv
// Randomized bench for qgate_pipe with a queue-based reference model.
// Also pins the model and the DUT with hand-computed vectors.
module tb_qgate_pipe;

  localparam longint K32 = 46341;
  localparam longint K16 = 181;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_mode = 2'd0;
  logic [31:0] in_alpha = '0;
  logic [31:0] in_beta = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_alpha;
  logic [31:0] out_beta;
  logic        out_sat;
  logic        ovf_sticky;
  logic        ovf_clr = 1'b0;

  logic        v2 = 1'b0;
  logic        r2;
  logic [1:0]  m2 = 2'd0;
  logic [15:0] a2 = '0;
  logic [15:0] b2 = '0;
  logic        ov2;
  logic        ordy2 = 1'b1;
  logic [15:0] oa2;
  logic [15:0] ob2;
  logic        os2;
  logic        st2;
  logic        clr2 = 1'b0;

  always #5 clk = ~clk;

  qgate_pipe #(.WIDTH(32), .FRAC(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_alpha   (in_alpha),
    .in_beta    (in_beta),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_alpha  (out_alpha),
    .out_beta   (out_beta),
    .out_sat    (out_sat),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr)
  );

  qgate_pipe #(.WIDTH(16), .FRAC(8)) dut16 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (v2),
    .in_ready   (r2),
    .in_mode    (m2),
    .in_alpha   (a2),
    .in_beta    (b2),
    .out_valid  (ov2),
    .out_ready  (ordy2),
    .out_alpha  (oa2),
    .out_beta   (ob2),
    .out_sat    (os2),
    .ovf_sticky (st2),
    .ovf_clr    (clr2)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          sat;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          sticky_m = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] pa;
  logic [31:0] pb;
  logic        ps;
  int          or_mode = 0;
  bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic longint sx(input logic [31:0] v, input int w);
    longint t;
    t = longint'(v) & ((longint'(1) <<< w) - 1);
    if (t >= (longint'(1) <<< (w - 1))) t -= (longint'(1) <<< w);
    return t;
  endfunction

  function automatic longint clampv(input longint v, input longint hi,
                                    input longint lo);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic void model(
    input int w, input int f, input longint k, input logic [1:0] m,
    input longint a, input longint b,
    output longint ra, output longint rb, output bit sat);
    longint x, y, hi, lo, half;
    hi   = (longint'(1) <<< (w - 1)) - 1;
    lo   = -hi - 1;
    half = longint'(1) <<< (f - 1);
    case (m)
      2'd0: begin x = a; y = b; end
      2'd1: begin x = b; y = a; end
      2'd2: begin x = a; y = -b; end
      default: begin
        x = ((a + b) * k + half) >>> f;
        y = ((a - b) * k + half) >>> f;
      end
    endcase
    sat = (x > hi) || (x < lo) || (y > hi) || (y < lo);
    ra  = clampv(x, hi, lo);
    rb  = clampv(y, hi, lo);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    exp_t   e;
    bit     eov;
    longint ra, rb;
    bit     s;
    if (rst) begin
      q.delete();
      sticky_m   = 1'b0;
      prev_stall = 1'b0;
      chk(out_valid == 1'b0, "rst_out_valid", longint'(out_valid), 0);
      chk(out_alpha == 0 && out_beta == 0 && out_sat == 0 && ovf_sticky == 0,
          "rst_outputs", longint'(out_alpha) ^ longint'(out_beta), 0);
    end else begin
      eov = (q.size() > 0) && (cyc >= q[0].acc + 2);
      chk(out_valid == eov, "out_valid", longint'(out_valid), longint'(eov));
      chk(in_ready == !(q.size() == 2 && !out_ready), "in_ready",
          longint'(in_ready), longint'(!(q.size() == 2 && !out_ready)));
      chk(ovf_sticky == sticky_m, "ovf_sticky",
          longint'(ovf_sticky), longint'(sticky_m));
      if (out_valid && q.size() > 0) begin
        e = q[0];
        chk(out_alpha == e.a, "alpha", longint'(out_alpha), longint'(e.a));
        chk(out_beta == e.b, "beta", longint'(out_beta), longint'(e.b));
        chk(out_sat == e.sat, "sat", longint'(out_sat), longint'(e.sat));
      end
      if (prev_stall)
        chk(out_alpha == pa && out_beta == pb && out_sat == ps, "stall_hold",
            longint'(out_alpha), longint'(pa));
      if (out_valid && out_ready && q.size() > 0) begin
        if (q[0].sat) sticky_m = 1'b1;
        else if (ovf_clr) sticky_m = 1'b0;
        void'(q.pop_front());
      end else if (ovf_clr) begin
        sticky_m = 1'b0;
      end
      if (in_valid && in_ready) begin
        model(32, 16, K32, in_mode, sx(in_alpha, 32), sx(in_beta, 32),
              ra, rb, s);
        e.a   = ra[31:0];
        e.b   = rb[31:0];
        e.sat = s;
        e.acc = cyc;
        q.push_back(e);
      end
      prev_stall = out_valid && !out_ready;
      pa = out_alpha;
      pb = out_beta;
      ps = out_sat;
    end
  end

  initial begin : ready_drv
    int pi;
    pi = 0;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = pat[pi];
          pi = (pi + 1) % 4;
        end
        2: begin
          out_ready = 1'($urandom_range(0, 1));
          ovf_clr = ($urandom_range(0, 7) == 0);
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic [31:0] a,
                      input logic [31:0] b);
    bit ok;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_alpha = a;
    in_beta  = b;
    do begin
      @(negedge clk);
      ok = in_ready;
      tick();
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout actual=%0d required=<200", n);
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [31:0] ea,
                            input logic [31:0] eb, input bit es,
                            output int lat);
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    chk(lat >= 0, {nm, "_valid"}, lat, 1);
    chk(out_alpha == ea, {nm, "_alpha"}, longint'(out_alpha), longint'(ea));
    chk(out_beta == eb, {nm, "_beta"}, longint'(out_beta), longint'(eb));
    chk(out_sat == es, {nm, "_sat"}, longint'(out_sat), longint'(es));
    tick();
  endtask

  task automatic run16(input string nm, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] ea,
                       input logic [15:0] eb, input bit es);
    bit ok;
    int n;
    v2 = 1'b1;
    m2 = 2'd3;
    a2 = a;
    b2 = b;
    n  = 0;
    do begin
      @(negedge clk);
      ok = r2;
      tick();
      n++;
    end while (!ok && n < 50);
    v2 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = ov2;
    end
    chk(ok, {nm, "_valid"}, longint'(ok), 1);
    chk(oa2 == ea, {nm, "_alpha"}, longint'(oa2), longint'(ea));
    chk(ob2 == eb, {nm, "_beta"}, longint'(ob2), longint'(eb));
    chk(os2 == es, {nm, "_sat"}, longint'(os2), longint'(es));
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", q.size());
    end
    tick();
  endtask

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h7FFF_0000;
      3: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    longint ra, rb;
    bit     s;
    int     lat;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick();

    model(32, 16, K32, 2'd3, 64'h10000, 0, ra, rb, s);
    chk(ra == 64'hB505 && rb == 64'hB505 && !s, "model_h1", ra, 64'hB505);
    model(32, 16, K32, 2'd3, 64'hB505, 64'hB505, ra, rb, s);
    chk(ra == 64'h10000 && rb == 0, "model_h2", ra, 64'h10000);
    model(32, 16, K32, 2'd2, 0, sx(32'h8000_0000, 32), ra, rb, s);
    chk(rb == 64'h7FFF_FFFF && s, "model_zmin", rb, 64'h7FFF_FFFF);
    model(16, 8, K16, 2'd3, 64'h100, 64'h100, ra, rb, s);
    chk(ra == 64'h16A && rb == 0 && !s, "model_w16", ra, 64'h16A);

    run16("w16_h", 16'h0100, 16'h0100, 16'h016A, 16'h0000, 1'b0);
    run16("w16_sat", 16'h7F00, 16'h7F00, 16'h7FFF, 16'h0000, 1'b1);

    send(2'd3, 32'h0001_0000, 32'h0);
    expect_out("h_one", 32'h0000_B505, 32'h0000_B505, 1'b0, lat);
    chk(lat == 1, "latency", lat, 1);
    send(2'd3, 32'h0000_B505, 32'h0000_B505);
    expect_out("h_back", 32'h0001_0000, 32'h0, 1'b0, lat);
    send(2'd1, 32'h0001_0000, 32'h0000_4000);
    expect_out("x_swap", 32'h0000_4000, 32'h0001_0000, 1'b0, lat);
    send(2'd3, 32'h7FFF_0000, 32'h7FFF_0000);
    expect_out("h_sat", 32'h7FFF_FFFF, 32'h0, 1'b1, lat);
    @(negedge clk);
    chk(ovf_sticky == 1'b1, "sticky_set", longint'(ovf_sticky), 1);
    tick();
    send(2'd2, 32'h0001_2345, 32'h8000_0000);
    expect_out("z_min", 32'h0001_2345, 32'h7FFF_FFFF, 1'b1, lat);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    @(negedge clk);
    chk(ovf_sticky == 1'b0, "sticky_clr", longint'(ovf_sticky), 0);
    tick();

    or_mode = 1;
    for (int i = 0; i < 8; i++) send(2'(i % 4), rval(), rval());
    or_mode = 0;
    drain();

    or_mode = 3;
    tick();
    send(2'd0, 32'h1111_1111, 32'h2222_2222);
    send(2'd3, 32'h0000_1000, 32'h0000_3000);
    chk(out_valid == 1'b1, "full_valid", longint'(out_valid), 1);
    chk(in_ready == 1'b0, "full_stall", longint'(in_ready), 0);
    #2 rst = 1'b1;
    #1;
    chk(out_valid == 1'b0, "async_rst_valid", longint'(out_valid), 0);
    chk(out_alpha == 0 && out_beta == 0 && out_sat == 0,
        "async_rst_data", longint'(out_alpha), 0);
    or_mode = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (6) tick();

    for (int seg = 0; seg < 3; seg++) begin
      or_mode = seg;
      for (int i = 0; i < 100; i++) begin
        send(2'($urandom_range(0, 3)), rval(), rval());
        repeat ($urandom_range(0, 2)) tick();
      end
      or_mode = 0;
      ovf_clr = 1'b0;
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
